// File: rtl/hist_rd.sv
// Histogram readout engine: sweeps bins 0..255 from the histogram RAM and
// streams each bin count with its running cumulative sum, optionally zeroing bins.
module hist_rd #(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned SUMWIDTH = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clr_en,
    output logic                busy,
    output logic                done,
    output logic                rden,
    output logic [7:0]          rdaddress,
    input  logic [BITWIDTH-1:0] q,
    output logic                wren,
    output logic [7:0]          wraddress,
    output logic [BITWIDTH-1:0] data,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic [7:0]          bin_idx,
    output logic [BITWIDTH-1:0] bin_cnt,
    output logic [SUMWIDTH-1:0] bin_cdf,
    output logic                bin_last
);

    localparam int unsigned SUM_EXT_W = SUMWIDTH + 1;

    typedef enum logic [2:0] {IDLE, READ, CAPT, OUT, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [SUMWIDTH-1:0] cdf_q, cdf_d;
    logic                clr_q, clr_d;
    logic                valid_q, valid_d;
    logic [7:0]          idx_q, idx_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [SUMWIDTH:0]   sum;

    // One extra bit catches overflow so the running sum can clamp.
    assign sum = {1'b0, cdf_q} + SUM_EXT_W'(q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cdf_q   <= '0;
            clr_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cdf_q   <= cdf_d;
            clr_q   <= clr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cdf_d   = cdf_q;
        clr_d   = clr_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rden    = 1'b0;
        wren    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    cdf_d   = '0;
                    clr_d   = clr_en;
                    state_d = READ;
                end
            end
            READ: begin
                rden    = 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                cnt_d   = q;
                idx_d   = addr_q;
                last_d  = (addr_q == 8'hff);
                cdf_d   = sum[SUMWIDTH] ? '1 : sum[SUMWIDTH-1:0];
                valid_d = 1'b1;
                wren    = clr_q;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && bin_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == 8'hff) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign rdaddress = addr_q;
    assign wraddress = addr_q;
    assign data      = '0;
    assign bin_valid = valid_q;
    assign bin_idx   = idx_q;
    assign bin_cnt   = cnt_q;
    assign bin_cdf   = cdf_q;
    assign bin_last  = last_q;

endmodule

// File: tb/tb_hist_rd.sv
// Directed bench for hist_rd: scenario table of full sweeps against a RAM model,
// plus hand-written reset-abort and saturation sequences.
module tb_hist_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clr_en, bin_ready;
    logic        busy, done, rden, wren, bin_valid, bin_last;
    logic [7:0]  rdaddress, wraddress, bin_idx;
    logic [15:0] q, data, bin_cnt;
    logic [23:0] bin_cdf;

    logic        s_start, s_ready, s_busy, s_done, s_rden, s_wren, s_valid, s_last;
    logic [7:0]  s_rdaddress, s_wraddress, s_idx;
    logic [15:0] s_q, s_data, s_cnt, s_cdf;

    logic        tb_we;
    logic [7:0]  tb_wa;
    logic [15:0] tb_wd;

    int total = 0;
    int bad   = 0;

    hist_rd u_dut (
        .clk(clk), .rst(rst), .start(start), .clr_en(clr_en), .busy(busy), .done(done),
        .rden(rden), .rdaddress(rdaddress), .q(q), .wren(wren), .wraddress(wraddress),
        .data(data), .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_idx(bin_idx),
        .bin_cnt(bin_cnt), .bin_cdf(bin_cdf), .bin_last(bin_last)
    );

    hist_rd #(.BITWIDTH(16), .SUMWIDTH(16)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .clr_en(1'b0), .busy(s_busy), .done(s_done),
        .rden(s_rden), .rdaddress(s_rdaddress), .q(s_q), .wren(s_wren), .wraddress(s_wraddress),
        .data(s_data), .bin_valid(s_valid), .bin_ready(s_ready), .bin_idx(s_idx),
        .bin_cnt(s_cnt), .bin_cdf(s_cdf), .bin_last(s_last)
    );

    // RAM models: registered read address, unregistered data, old-data on collision.
    logic [15:0] mem   [256];
    logic [15:0] s_mem [256];
    logic [7:0]  ra   = 8'd0;
    logic [7:0]  s_ra = 8'd0;

    always @(posedge clk) begin
        if (rden) ra <= rdaddress;
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (wren) mem[wraddress] <= data;
    end
    always @(posedge clk) begin
        if (s_rden) s_ra <= s_rdaddress;
        if (tb_we) s_mem[tb_wa] <= 16'h1000;
        else if (s_wren) s_mem[s_wraddress] <= s_data;
    end
    assign q   = mem[ra];
    assign s_q = s_mem[s_ra];

    typedef struct {
        int          kind;       // 0: bin[i]=i, 1: bin[i]=0xFFFF
        bit          clr;
        int          duty;       // bin_ready duty in percent
        bit          restart;    // extra start pulse at cycle 100
        logic [23:0] final_cdf;
    } scen_t;

    scen_t tbl [4];

    function automatic logic [15:0] pat(input int kind, input int i);
        return (kind == 0) ? 16'(i) : 16'hffff;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({busy, done, rden, wren, bin_valid, bin_last} == 6'd0, {tag, "_flags"},
            64'({busy, done, rden, wren, bin_valid, bin_last}), 64'd0);
        chk({rdaddress, wraddress, bin_idx} == 24'd0, {tag, "_addr"},
            64'({rdaddress, wraddress, bin_idx}), 64'd0);
        chk({data, bin_cnt, bin_cdf} == 56'd0, {tag, "_data"}, 64'({data, bin_cnt, bin_cdf}), 64'd0);
    endtask

    task automatic preload(input int kind);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            tb_we = 1'b1;
            tb_wa = 8'(i);
            tb_wd = pat(kind, i);
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run_sweep(input scen_t s);
        int cyc = 0, beats = 0, first_v = -1, done_cyc = -1, wr_n = 0, ram_bad = 0;
        bit fin = 0, stall = 0;
        logic [23:0] ecdf = 24'd0;
        logic [7:0]  pi = 8'd0;
        logic [15:0] pc = 16'd0;
        logic [23:0] pd = 24'd0;
        logic        pl = 1'b0;
        logic [15:0] exp_ram;
        @(negedge clk);
        clr_en    = s.clr;
        start     = 1'b1;
        bin_ready = 1'b1;
        @(posedge clk);
        while (!fin && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            clr_en    = 1'b0;
            start     = (s.restart && cyc == 100);
            bin_ready = (s.duty >= 100) ? 1'b1 : ($urandom_range(99) < 32'(s.duty));
            if (stall)
                chk(bin_valid && bin_idx == pi && bin_cnt == pc && bin_cdf == pd && bin_last == pl,
                    "hold_stall", 64'({bin_valid, bin_idx, bin_cnt}), 64'({1'b1, pi, pc}));
            if (bin_valid) begin
                chk(!rden, "rden_in_out", 64'(rden), 64'd0);
                if (first_v < 0) first_v = cyc;
            end
            if (wren) begin
                chk(s.clr && wraddress == 8'(wr_n) && data == 16'd0, "clear_write",
                    64'({wraddress, data}), 64'({8'(wr_n), 16'd0}));
                wr_n++;
            end
            if (bin_valid && bin_ready) begin
                ecdf = ecdf + 24'(pat(s.kind, beats));
                chk(bin_idx == 8'(beats), "beat_idx", 64'(bin_idx), 64'(beats));
                chk(bin_cnt == pat(s.kind, beats), "beat_cnt", 64'(bin_cnt), 64'(pat(s.kind, beats)));
                chk(bin_cdf == ecdf, "beat_cdf", 64'(bin_cdf), 64'(ecdf));
                chk(bin_last == (beats == 255), "beat_last", 64'(bin_last), 64'(beats == 255));
                beats++;
            end
            stall = bin_valid && !bin_ready;
            pi = bin_idx; pc = bin_cnt; pd = bin_cdf; pl = bin_last;
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
        end
        start = 1'b0;
        chk(fin, "done_timeout", 64'(fin), 64'd1);
        chk(beats == 256, "beat_count", 64'(beats), 64'd256);
        chk(first_v == 3, "first_valid_cycle", 64'(first_v), 64'd3);
        if (s.duty >= 100) chk(done_cyc == 769, "done_cycle", 64'(done_cyc), 64'd769);
        chk(bin_cdf == s.final_cdf, "final_cdf", 64'(bin_cdf), 64'(s.final_cdf));
        chk(wr_n == (s.clr ? 256 : 0), "clear_count", 64'(wr_n), 64'(s.clr ? 256 : 0));
        @(negedge clk);
        chk(!busy && !done, "post_done", 64'({busy, done}), 64'd0);
        for (int i = 0; i < 256; i++) begin
            exp_ram = s.clr ? 16'd0 : pat(s.kind, i);
            if (mem[i] !== exp_ram) ram_bad++;
        end
        chk(ram_bad == 0, "ram_after", 64'(ram_bad), 64'd0);
    endtask

    initial begin
        int n, ok_done, beats;
        bit hit;
        tbl[0] = '{kind: 0, clr: 1'b0, duty: 100, restart: 1'b1, final_cdf: 24'd32640};
        tbl[1] = '{kind: 0, clr: 1'b1, duty: 100, restart: 1'b0, final_cdf: 24'd32640};
        tbl[2] = '{kind: 0, clr: 1'b0, duty: 30,  restart: 1'b0, final_cdf: 24'd32640};
        tbl[3] = '{kind: 1, clr: 1'b1, duty: 100, restart: 1'b0, final_cdf: 24'hffff00};

        rst = 1'b1; start = 1'b0; clr_en = 1'b0; bin_ready = 1'b0;
        s_start = 1'b0; s_ready = 1'b0; tb_we = 1'b0; tb_wa = 8'd0; tb_wd = 16'd0;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Abort a sweep while bin 40 is stalled in OUT.
        preload(0);
        @(negedge clk);
        start = 1'b1; bin_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            if (bin_valid && bin_idx == 8'd40) begin
                bin_ready = 1'b0;
                hit = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk(hit, "reach_bin40", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        ok_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) ok_done++;
        end
        chk(ok_done == 0, "no_done_after_abort", 64'(ok_done), 64'd0);

        for (int t = 0; t < 4; t++) begin
            preload(tbl[t].kind);
            run_sweep(tbl[t]);
        end

        // Saturating instance: s_mem holds 0x1000 in every bin.
        @(negedge clk);
        s_start = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        beats = 0; n = 0; hit = 0;
        while (!hit && n < 2000) begin
            if (s_valid && s_ready) begin
                chk(s_cdf == ((beats <= 14) ? 16'(32'h1000 * (beats + 1)) : 16'hffff), "sat_cdf",
                    64'(s_cdf), 64'((beats <= 14) ? 16'(32'h1000 * (beats + 1)) : 16'hffff));
                beats++;
            end
            if (s_done) hit = 1;
            @(negedge clk);
            n++;
        end
        chk(hit && beats == 256, "sat_sweep", 64'(beats), 64'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
